call_stack: RTL
===============

// Module: call_stack
// PURPOSE
//  Return-address LIFO directly upstream of the program counter. On a subroutine call
//  it pushes (instr_addr + 1) and, together with the counter's jmp path, redirects fetch.
//  On a return it presents the top entry on ret_addr and pops it on the same edge on
//  which the counter loads ret_addr. It also reports occupancy and sticky overflow/underflow errors.
// PARAMETERS
//  INSTR_ADDR_SIZE  5  width of instruction addresses; must match the program counter
//  STACK_DEPTH      8  number of return-address entries, >= 2
// PORTS
//  clk         in   1                  rising-edge clock
//  rst         in   1                  synchronous, active-high reset
//  call        in   1                  push request; the decoder asserts jmp in the same cycle
//  ret         in   1                  pop request; drives the counter's ret input
//  instr_addr  in   INSTR_ADDR_SIZE    current address from the program counter
//  err_clr     in   1                  clears the sticky error flags
//  ret_addr    out  INSTR_ADDR_SIZE    top of stack to the counter; combinational read of registered storage
//  depth       out  $clog2(STACK_DEPTH+1)  number of valid entries
//  empty       out  1                  depth == 0
//  full        out  1                  depth == STACK_DEPTH
//  overflow    out  1                  sticky: a push was attempted while full
//  underflow   out  1                  sticky: a pop was attempted while empty
// BEHAVIOUR
//  - All state updates on posedge clk. Reset is synchronous: when rst=1 at the edge,
//    depth=0, overflow=0, underflow=0, and all entries are cleared to 0.
//    As a result, after reset ret_addr=0, empty=1 and full=0. rst overrides every other input.
//  - ret_addr = entry[depth-1] when depth>0, else 0. It must be valid before the edge
//    on which ret=1, because the counter samples ret_addr on that same edge. Pop latency is 0 cycles.
//  - Push (call=1, not full): entry[depth] <= instr_addr + 1, truncated to INSTR_ADDR_SIZE
//    bits. The increment wraps, so 5'h1F pushes 5'h00. depth increments by 1.
//  - Pop (ret=1, call=0, not empty): depth decrements by 1. Entry contents are left stale.
//  - call=1 and ret=1 together: the counter gives jmp priority, so the stack does the same.
//    The push is performed and ret is ignored (no pop, no underflow).
//  - Push while full: no write, depth unchanged, overflow <= 1.
//  - Pop while empty: depth unchanged, ret_addr stays 0, underflow <= 1.
//  - err_clr=1 clears both flags on that edge. If an error occurs on the same edge,
//    the set wins and the flag stays 1.
//  - No state machine beyond the occupancy counter. Valid depth range is 0..STACK_DEPTH
//    and depth can never wrap.
//  - A reset while entries are held discards them; the following cycle behaves as power-up.
// STRUCTURE
//  - Shared package pbl_pkg holds:
//      - INSTR_ADDR_SIZE default constant and typedef instr_addr_t, so call_stack and pc agree on width;
//      - STACK_DEPTH default constant.
//  - No sub-module. Storage is an inline register array of STACK_DEPTH x instr_addr_t,
//    and depth uses a single counter register.
// TESTING
//  1 reset: hold rst=1 for 2 cycles with call=1 -> depth=0, empty=1, ret_addr=0, overflow=0, underflow=0
//  2 push/pop: call at instr_addr=3, then at instr_addr=9 -> ret_addr=10, depth=2;
//    ret -> ret_addr=4, depth=1; ret -> empty=1
//  3 full: 8 calls at addrs 0..7 -> full=1, ret_addr=8; 9th call at 20 -> overflow=1,
//    depth=8, ret_addr=8; err_clr -> overflow=0
//  4 empty pop: after reset ret=1 -> underflow=1, depth=0, ret_addr=0;
//    err_clr and ret in the same cycle -> underflow stays 1
//  5 simultaneous: depth=1 (top 5), call=1 and ret=1 at instr_addr=12 -> depth=2, ret_addr=13, underflow=0
//  6 wrap and reset mid-use: call at 5'h1F -> ret_addr=0;
//    push 3 entries, rst for 1 cycle -> depth=0, ret_addr=0

Source files
------------

// File: rtl/pbl_pkg.sv
// rtl/pbl_pkg.sv - shared widths so the program counter and call stack agree
package pbl_pkg;

    localparam int INSTR_ADDR_SIZE = 5;
    localparam int STACK_DEPTH     = 8;

    typedef logic [INSTR_ADDR_SIZE-1:0] instr_addr_t;

endpackage

// File: rtl/call_stack_if.sv
// rtl/call_stack_if.sv - decoder/counter-side bundle for the return-address stack
interface call_stack_if #(
    parameter int INSTR_ADDR_SIZE = pbl_pkg::INSTR_ADDR_SIZE,
    parameter int STACK_DEPTH     = pbl_pkg::STACK_DEPTH
);

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic                       call;
    logic                       ret;
    logic [INSTR_ADDR_SIZE-1:0] instr_addr;
    logic                       err_clr;
    logic [INSTR_ADDR_SIZE-1:0] ret_addr;
    logic [DEPTH_W-1:0]         depth;
    logic                       empty;
    logic                       full;
    logic                       overflow;
    logic                       underflow;

    modport master (
        output call, ret, instr_addr, err_clr,
        input  ret_addr, depth, empty, full, overflow, underflow
    );

    modport slave (
        input  call, ret, instr_addr, err_clr,
        output ret_addr, depth, empty, full, overflow, underflow
    );

endinterface

// File: rtl/call_stack.sv
// rtl/call_stack.sv - return-address LIFO feeding the program counter
import pbl_pkg::*;

module call_stack #(
    parameter int INSTR_ADDR_SIZE = pbl_pkg::INSTR_ADDR_SIZE,
    parameter int STACK_DEPTH     = pbl_pkg::STACK_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    call_stack_if.slave  bus
);

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef logic [INSTR_ADDR_SIZE-1:0] addr_t;

    addr_t              entry [STACK_DEPTH];
    logic [DEPTH_W-1:0] depth_q;
    logic               overflow_q;
    logic               underflow_q;

    logic               is_empty;
    logic               is_full;
    logic               pop_req;
    logic               do_push;
    logic               do_pop;
    logic [DEPTH_W-1:0] depth_m1;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   top_idx;

    assign is_empty = (depth_q == '0);
    assign is_full  = (depth_q == DEPTH_W'(STACK_DEPTH));

    // call wins over ret, matching the counter's jmp priority
    assign pop_req  = bus.ret & ~bus.call;
    assign do_push  = bus.call & ~is_full;
    assign do_pop   = pop_req & ~is_empty;

    assign depth_m1 = depth_q - DEPTH_W'(1);
    assign wr_idx   = depth_q[IDX_W-1:0];
    assign top_idx  = depth_m1[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                entry[i] <= '0;
            end
        end else begin
            if (do_push) begin
                entry[wr_idx] <= bus.instr_addr + INSTR_ADDR_SIZE'(1);
                depth_q       <= depth_q + DEPTH_W'(1);
            end else if (do_pop) begin
                depth_q <= depth_m1;
            end
            // a new error on the clearing edge keeps the flag set
            overflow_q  <= (bus.call & is_full) | (overflow_q & ~bus.err_clr);
            underflow_q <= (pop_req & is_empty) | (underflow_q & ~bus.err_clr);
        end
    end

    assign bus.ret_addr  = is_empty ? '0 : entry[top_idx];
    assign bus.depth     = depth_q;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

endmodule
